// File: rtl/vr_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
package vr_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Modulo increment that stays correct for non-power-of-two requester counts.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/vr_packet_arbiter_if.sv
// Requester-side and sink-side valid-ready bundle of the packet arbiter.
interface vr_packet_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [DATA_W-1:0]              out_data;
  logic                           out_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [ID_W-1:0]                grant_id;
  logic                           grant_active;

  // Arbiter side.
  modport master (
    input  req_data, req_last, req_valid, out_ready,
    output req_ready, out_data, out_last, out_valid, grant_id, grant_active
  );

  // Requesters plus sink side.
  modport slave (
    output req_data, req_last, req_valid, out_ready,
    input  req_ready, out_data, out_last, out_valid, grant_id, grant_active
  );

endinterface

// File: rtl/vr_packet_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, with wrap.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    pick_id,
  output logic               pick_any
);

  // Scan NUM_REQ candidates starting at rr_ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    pick_id  = '0;
    pick_any = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_any && req_valid[ID_W'(idx)]) begin
        pick_any = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vr_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered valid-ready stage.
module vr_packet_arbiter
  import vr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
) (
  input logic                 clk,
  input logic                 nrst,
  input logic                 en,
  input logic                 sync_rst,
  vr_packet_arbiter_if.master bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic              can_load;
  logic              accept;
  logic [NUM_REQ-1:0] req_ready;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .pick_id   (pick_id),
    .pick_any  (pick_any)
  );

  // The out register can take a beat when empty or draining this cycle.
  assign can_load = en & (~out_valid_q | bus.out_ready);

  // Only the locked requester ever sees ready; no path from req_valid.
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_LOCKED) req_ready[grant_id_q] = can_load;
  end

  assign accept = (state_q == ARB_LOCKED) & bus.req_valid[grant_id_q] & can_load;

  // Grant FSM: lock on arbitration, release after the last beat is accepted.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (en && pick_any) begin
          state_d    = ARB_LOCKED;
          grant_id_d = pick_id;
        end
      end
      ARB_LOCKED: begin
        if (accept && bus.req_last[grant_id_q]) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = ID_W'(rr_next(32'(grant_id_q), NUM_REQ));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Out stage: load on accept, otherwise clear valid once the sink takes it.
  always_comb begin
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = bus.req_data[grant_id_q];
      out_last_d  = bus.req_last[grant_id_q];
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; either reset source abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!nrst || sync_rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.out_data     = out_data_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_vr_packet_arbiter.sv
// Bench for vr_packet_arbiter: directed scenarios plus random traffic vs a packet-level model.
module tb_vr_packet_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, en, sync_rst, rdy;

  vr_packet_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();
  vr_packet_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  // Three-requester build to exercise pointer wrap on a non-power-of-two count.
  vr_packet_arbiter_if #(.NUM_REQ(3), .DATA_W(8)) bus3 ();
  vr_packet_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (
    .clk      (clk),
    .nrst     (nrst),
    .en       (1'b1),
    .sync_rst (1'b0),
    .bus      (bus3)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-requester beat sources ({last, data}) as ring buffers.
  logic [32:0] src_mem [4][256];
  int          src_wr [4];
  int          src_rd [4];
  bit          hold   [4];

  // Reference model: grant lock, rr pointer, and contents of the out stage.
  bit          m_locked;
  int          m_gid;
  int          m_ptr;
  logic [32:0] pend [$];
  logic [32:0] sink_q [$];
  int          g3_q [$];
  bit          g3_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input logic [31:0] base);
    for (int b = 0; b < len; b++) begin
      src_mem[r][src_wr[r] % 256] = {(b == len - 1), base + 32'(b)};
      src_wr[r]++;
    end
  endtask

  task automatic clear_src();
    for (int r = 0; r < N; r++) begin
      src_wr[r] = 0;
      src_rd[r] = 0;
      hold[r]   = 0;
    end
  endtask

  // One cycle: drive at negedge, check #1 later, advance model, wait for next negedge.
  task automatic step();
    logic [3:0]  v;
    logic [3:0]  exp_rdy;
    logic [32:0] hd;
    bit          was_locked, acc, found;
    for (int r = 0; r < N; r++) begin
      v[r] = (src_rd[r] != src_wr[r]) && !hold[r];
      hd   = (src_rd[r] != src_wr[r]) ? src_mem[r][src_rd[r] % 256] : 33'd0;
      bus.req_data[r] = hd[31:0];
      bus.req_last[r] = hd[32];
    end
    bus.req_valid = v;
    bus.out_ready = rdy;
    #1;
    exp_rdy = '0;
    if (m_locked && en && (pend.size() == 0 || rdy)) exp_rdy[m_gid] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("out_valid", 64'(bus.out_valid), 64'(pend.size() != 0));
    if (pend.size() != 0) chk("out_beat", 64'({bus.out_last, bus.out_data}), 64'(pend[0]));
    chk("grant_active", 64'(bus.grant_active), 64'(m_locked));
    chk("grant_id", 64'(bus.grant_id), 64'(m_gid));
    if (bus.out_valid && rdy) sink_q.push_back({bus.out_last, bus.out_data});
    if (bus3.grant_active && !g3_prev) g3_q.push_back(int'(bus3.grant_id));
    g3_prev = bus3.grant_active;

    if (!nrst || sync_rst) begin
      m_locked = 0;
      m_gid    = 0;
      m_ptr    = 0;
      pend.delete();
    end else begin
      was_locked = m_locked;
      acc = m_locked && v[m_gid] && en && (pend.size() == 0 || rdy);
      if (pend.size() != 0 && rdy) void'(pend.pop_front());
      if (was_locked) begin
        if (acc) begin
          hd = src_mem[m_gid][src_rd[m_gid] % 256];
          pend.push_back(hd);
          src_rd[m_gid]++;
          if (hd[32]) begin
            m_locked = 0;
            m_ptr    = (m_gid + 1) % N;
          end
        end
      end else if (en) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && v[(m_ptr + k) % N]) begin
            found    = 1;
            m_locked = 1;
            m_gid    = (m_ptr + k) % N;
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit use_sync);
    if (use_sync) sync_rst = 1'b1;
    else nrst = 1'b0;
    step();
    nrst     = 1'b1;
    sync_rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_last"}, 64'(bus.out_last), 64'd0);
    chk({tag, "_data"}, 64'(bus.out_data), 64'd0);
    chk({tag, "_active"}, 64'(bus.grant_active), 64'd0);
    chk({tag, "_gid"}, 64'(bus.grant_id), 64'd0);
    chk({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
  endtask

  initial begin
    logic [32:0] exp_q [$];
    nrst           = 1'b0;
    sync_rst       = 1'b0;
    en             = 1'b1;
    rdy            = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_last   = '0;
    bus.out_ready  = 1'b1;
    bus3.req_valid = '0;
    bus3.req_data  = '0;
    bus3.req_last  = '1;
    bus3.out_ready = 1'b1;
    clear_src();
    m_locked = 0;
    m_gid    = 0;
    m_ptr    = 0;
    g3_prev  = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_zero("por");
    nrst = 1'b1;

    // Single requester, 3-beat packet.
    sink_q.delete();
    push_pkt(0, 3, 32'hA0);
    for (int i = 0; i < 8; i++) step();
    chk("t1_count", 64'(sink_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < sink_q.size(); i++)
      chk("t1_beat", 64'(sink_q[i]), 64'({(i == 2), 32'hA0 + 32'(i)}));

    // All four continuously valid with 1-beat packets.
    do_reset(0);
    sink_q.delete();
    for (int r = 0; r < N; r++) begin
      push_pkt(r, 1, 32'h100 + 32'(r * 16));
      push_pkt(r, 1, 32'h101 + 32'(r * 16));
    end
    for (int i = 0; i < 20; i++) step();
    exp_q = '{33'h1_0000_0100, 33'h1_0000_0110, 33'h1_0000_0120, 33'h1_0000_0130,
              33'h1_0000_0101};
    chk("t2_count", 64'(sink_q.size()), 64'd8);
    for (int i = 0; i < 5 && i < sink_q.size(); i++) chk("t2_order", 64'(sink_q[i]), 64'(exp_q[i]));

    // Requester 2 pauses mid-packet while the others wait.
    do_reset(0);
    sink_q.delete();
    push_pkt(2, 4, 32'h200);
    step();
    push_pkt(0, 1, 32'h300);
    push_pkt(1, 1, 32'h301);
    push_pkt(3, 1, 32'h303);
    for (int i = 0; i < 20 && src_rd[2] < 2; i++) step();
    chk("t3_progress", 64'(src_rd[2]), 64'd2);
    hold[2] = 1;
    for (int i = 0; i < 5; i++) step();
    hold[2] = 0;
    for (int i = 0; i < 20; i++) step();
    exp_q = '{33'h0_0000_0200, 33'h0_0000_0201, 33'h0_0000_0202, 33'h1_0000_0203,
              33'h1_0000_0303, 33'h1_0000_0300, 33'h1_0000_0301};
    chk("t3_count", 64'(sink_q.size()), 64'd7);
    for (int i = 0; i < 7 && i < sink_q.size(); i++) chk("t3_order", 64'(sink_q[i]), 64'(exp_q[i]));

    // Sink backpressure for 4 cycles mid-packet.
    do_reset(0);
    sink_q.delete();
    push_pkt(1, 6, 32'h400);
    for (int i = 0; i < 3; i++) step();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rdy = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("t4_count", 64'(sink_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < sink_q.size(); i++)
      chk("t4_beat", 64'(sink_q[i]), 64'({(i == 5), 32'h400 + 32'(i)}));

    // Reset mid-packet, first via nrst then via sync_rst.
    for (int s = 0; s < 2; s++) begin
      do_reset(0);
      push_pkt(3, 4, 32'h500);
      for (int i = 0; i < 3; i++) step();
      if (s == 0) nrst = 1'b0;
      else sync_rst = 1'b1;
      step();
      chk_zero(s == 0 ? "t5n" : "t5s");
      nrst     = 1'b1;
      sync_rst = 1'b0;
      clear_src();
      sink_q.delete();
      push_pkt(0, 1, 32'h600);
      push_pkt(3, 1, 32'h603);
      for (int i = 0; i < 10; i++) step();
      chk("t5_count", 64'(sink_q.size()), 64'd2);
      if (sink_q.size() != 0) chk("t5_first", 64'(sink_q[0]), 64'(33'h1_0000_0600));
    end

    // Enable low for 3 cycles with a pending beat.
    do_reset(0);
    sink_q.delete();
    push_pkt(0, 3, 32'h700);
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t6_drained", 64'(sink_q.size()), 64'd1);
    en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t6_count", 64'(sink_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < sink_q.size(); i++)
      chk("t6_beat", 64'(sink_q[i]), 64'({(i == 2), 32'h700 + 32'(i)}));

    // Three-requester wrap 2 -> 0.
    do_reset(0);
    g3_q.delete();
    bus3.req_valid = 3'b111;
    for (int i = 0; i < 14; i++) step();
    bus3.req_valid = 3'b000;
    chk("t7_grants", 64'(g3_q.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < g3_q.size(); i++) chk("t7_order", 64'(g3_q[i]), 64'(i % 3));

    // Random traffic against the model.
    do_reset(0);
    clear_src();
    for (int i = 0; i < 800; i++) begin
      for (int r = 0; r < N; r++) begin
        if (src_rd[r] == src_wr[r] && $urandom_range(0, 3) == 0)
          push_pkt(r, int'($urandom_range(1, 4)),
                   {8'(r), 8'(i), 8'h00, 8'($urandom_range(0, 255))} & 32'hFFFF_00F0);
        hold[r] = ($urandom_range(0, 9) < 2);
      end
      rdy      = ($urandom_range(0, 9) < 7);
      en       = ($urandom_range(0, 19) != 0);
      sync_rst = ($urandom_range(0, 199) == 0);
      step();
    end
    en       = 1'b1;
    sync_rst = 1'b0;
    rdy      = 1'b1;
    for (int r = 0; r < N; r++) hold[r] = 0;
    for (int i = 0; i < 100; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vr_packet_arbiter.md
# vr_packet_arbiter

Packet-granular round-robin arbiter that shares one valid-ready sink, typically the write port of a `fifo_vr` instance, between `NUM_REQ` valid-ready requesters. A grant locks to one requester from its first beat until its `last` beat is accepted, so packets never interleave in the shared FIFO. The output is a single registered stage that drives `data_in*` of the downstream FIFO directly.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `DATA_W`, 32: beat width.
- `ID_W`, `$clog2(NUM_REQ)`: localparam, width of the grant index.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `nrst`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `en`  in  1  block enable; low stalls all transfers.
- `sync_rst`  in  1  synchronous local reset, active-high; same effect as `nrst`=0.
- `req_data`  in  `NUM_REQ`×`DATA_W`  per-requester beat.
- `req_last`  in  `NUM_REQ`  per-requester end-of-packet flag.
- `req_valid`  in  `NUM_REQ`  per-requester valid.
- `req_ready`  out  `NUM_REQ`  per-requester ready; at most one bit high.
- `out_data`  out  `DATA_W`  registered beat to the sink.
- `out_last`  out  1  registered last flag.
- `out_valid`  out  1  registered valid.
- `out_ready`  in  1  sink ready, e.g. `data_in_ready` of the FIFO.
- `grant_id`  out  `ID_W`  index of the current or most recent grant.
- `grant_active`  out  1  high while in LOCKED.

## Operation
- States: IDLE, LOCKED.
- In IDLE with `en`=1 and any `req_valid`, pick the first valid requester at or after `rr_ptr`, searching with wrap-around. On the next edge: load `grant_id`, move to LOCKED, set `grant_active`=1.
- In IDLE, `req_ready` is all 0.
- In LOCKED: `req_ready[grant_id]` = `en` & (!`out_valid` | `out_ready`). All other `req_ready` bits are 0.
- A beat is accepted when `req_valid[g]` & `req_ready[g]`. The beat's data and last flag load into the out register, and `out_valid` is 1 on the next cycle.
- If the out register is drained (`out_valid` & `out_ready`) with no new accept in the same cycle, `out_valid` goes 0 on the next cycle.
- When a beat with last=1 is accepted:
  - return to IDLE on the next edge;
  - `rr_ptr` becomes (`grant_id`+1) mod `NUM_REQ`;
  - `grant_active` goes to 0.
- `grant_id` holds its value in IDLE.
- The grant is held across idle gaps: a locked requester that drops `req_valid` mid-packet keeps the grant indefinitely. No timeout.
- `en`=0 effects:
  - `req_ready` is forced to 0;
  - state, `rr_ptr` and the out register hold;
  - `out_valid` stays asserted if it was set, so a pending beat can still drain when `out_ready` is high (valid never drops before it is accepted);
  - no new grant is taken.
- Reset (`nrst`=0 or `sync_rst`=1 at an edge):
  - state goes to IDLE and `rr_ptr` to 0;
  - `out_valid`, `out_last`, `out_data`, `grant_active` and `grant_id` all go to 0, and `req_ready` reads 0;
  - reset wins over every other event, including mid-packet. A partially sent packet is abandoned, and the sink sees no further beats of it.
- `rr_ptr` arithmetic is modulo `NUM_REQ` and must be correct for non-power-of-two `NUM_REQ`.

## Timing
- `req_ready` is combinational from state, `grant_id`, `en`, `out_valid` and `out_ready`. There is no combinational path from `req_valid` to `req_ready`.
- All other outputs are registered.
- Arbitration latency: a request first seen valid in IDLE at cycle 0 is granted (LOCKED) at cycle 1. Its first beat can be accepted at cycle 1 and appears on `out_valid` at cycle 2.
- Throughput inside a packet: one beat per cycle while `out_ready`=1.
- Packet boundary: last beat accepted at cycle k → IDLE at k+1 → next grant at k+2. This gives one dead cycle between packets, by design.
- Sink backpressure: while `out_ready`=0 with `out_valid`=1, `req_ready`=0 and `out_data`/`out_last` are stable.

## Structure
- Package `vr_arb_pkg`:
  - `typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_t`;
  - function `rr_next(ptr, n)` for the modulo increment.
- One combinational sub-module `rr_priority_pick`, parameterised by `NUM_REQ`. Inputs: `req_valid` vector and `rr_ptr`. Outputs: `pick_id` and `pick_any`. Reusable by future schedulers.
- The out register and FSM stay in the top module.

## Test plan
- Single requester, 3-beat packet (data 0xA0..0xA2, last on 0xA2), `out_ready`=1 → grant at cycle 1; `out_valid` cycles 2–4 carrying 0xA0, 0xA1, 0xA2; `grant_active` low at cycle 4.
- All 4 requesters continuously valid with 1-beat packets → grant order 0, 1, 2, 3, 0, one beat every 2 cycles, never interleaved.
- Requester 2 mid-packet drops `req_valid` for 5 cycles while 0, 1 and 3 are valid → grant stays 2 and resumes; the others are served only after 2's last beat.
- `out_ready` held 0 for 4 cycles mid-packet → `out_data` stable and `req_ready`=0 throughout; no beat lost or duplicated after release; the sink FIFO contents match the sent order.
- Assert `nrst`=0 for one cycle mid-packet, then with `sync_rst`=1 in a second run → next cycle all outputs 0, state IDLE, `rr_ptr`=0; requester 0 wins the next arbitration.
- `en`=0 for 3 cycles with `out_valid`=1 and `out_ready`=1 → pending beat drains, no new accept; `NUM_REQ`=3 build checks `rr_ptr` wraps 2→0.
